inst_fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the multi-cycle data-processing core: holds PC and IR,

---
 rtl/inst_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction fetch stage for the multi-cycle data-processing core. Holds the
//   program counter (PC) and instruction register (IR), fetches from a
//   variable-latency instruction memory over a req/ack handshake, and evaluates
//   the ARM condition field of the held instruction against the core's NZCV.
//
//   Ports
//     clk        in   1       clock, all state updates on posedge
//     Rst        in   1       asynchronous, active-high reset
//     Write_PC   in   1       increment PC when the accompanying fetch completes
//     Write_IR   in   1       start a fetch at the current PC
//     NZCV       in   4       core flags: [3]=N [2]=Z [1]=C [0]=V
//     mem_req    out  1       fetch request to instruction memory
//     mem_addr   out  ADDR_W  fetch word address (= PC)
//     mem_ack    in   1       memory: mem_rdata valid this cycle
//     mem_rdata  in   32      fetched instruction word
//     Inst_addr  out  ADDR_W  current PC
//     IR         out  32      held instruction word
//     ir_valid   out  1       IR holds a completed fetch
//     flag       out  1       ir_valid AND condition of IR[31:28] passes
//     busy       out  1       fetch in progress
//     fetch_err  out  1       one-cycle pulse: fetch aborted on timeout
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int                 ADDR_W   = 6,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
  parameter int                 TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              Write_PC,
  input  logic              Write_IR,
  input  logic [3:0]        NZCV,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] Inst_addr,
  output logic [31:0]       IR,
  output logic              ir_valid,
  output logic              flag,
  output logic              busy,
  output logic              fetch_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Counter must be able to hold TIMEOUT-1; at least one bit wide.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] pc_q,        pc_d;
  logic [31:0]       ir_q,        ir_d;
  logic              ir_valid_q,  ir_valid_d;
  logic              mem_req_q,   mem_req_d;
  logic              fetch_err_q, fetch_err_d;
  logic              pc_inc_q,    pc_inc_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  // ARM condition-code evaluation against flags {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = ~c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = c & ~z;
      4'h9:    cond_pass = ~c | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Next-state logic for the IDLE/REQ/HOLD fetch controller.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    mem_req_d   = mem_req_q;
    fetch_err_d = 1'b0;
    pc_inc_d    = pc_inc_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        // Write_PC on its own does nothing; it only qualifies a fetch.
        if (Write_IR) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          pc_inc_d   = Write_PC;
          cnt_d      = {CNT_W{1'b0}};
          ir_valid_d = 1'b0;
        end else begin
          state_d    = state_q;
        end
      end
      ST_REQ: begin
        // An ack on the final timeout cycle still completes the fetch.
        if (mem_ack) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = ST_HOLD;
          if (pc_inc_q) begin
            pc_d = pc_q + PC_ONE;
          end else begin
            pc_d = pc_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d   = 1'b0;
          fetch_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        mem_req_d  = 1'b0;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= 32'h0000_0000;
      ir_valid_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      fetch_err_q <= 1'b0;
      pc_inc_q    <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      mem_req_q   <= mem_req_d;
      fetch_err_q <= fetch_err_d;
      pc_inc_q    <= pc_inc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = pc_q;
  assign Inst_addr = pc_q;
  assign IR        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign busy      = (state_q == ST_REQ);
  assign fetch_err = fetch_err_q;
  // Uses live NZCV so the core sees flag updates without waiting a cycle.
  assign flag      = ir_valid_q & cond_pass(ir_q[31:28], NZCV);

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        Rst;
  logic        Write_PC, Write_IR;
  logic [3:0]  NZCV;
  logic        mem_req;
  logic [5:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [5:0]  Inst_addr;
  logic [31:0] IR;
  logic        ir_valid, flag, busy, fetch_err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] ir;
    logic [5:0]  pc;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [5:0]  exp_pc;
  logic [31:0] exp_ir;

  inst_fetch_unit #(.ADDR_W(6), .RESET_PC(6'd0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .Rst(Rst), .Write_PC(Write_PC), .Write_IR(Write_IR), .NZCV(NZCV),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .Inst_addr(Inst_addr), .IR(IR), .ir_valid(ir_valid), .flag(flag),
    .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Reference condition table.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Issue one fetch; ack sampled n edges after Write_IR (n=0: never ack).
  // poke keeps Write_IR/Write_PC high during REQ. Completion pops the scoreboard.
  task automatic run_fetch(input logic wpc, input logic [31:0] rdata, input int n,
                           input logic poke, output int rc);
    exp_t e;
    exp_t got;
    bit   done;
    e.err   = (n == 0) || (n > TIMEOUT);
    e.valid = !e.err;
    e.ir    = e.err ? exp_ir : rdata;
    e.pc    = (!e.err && wpc) ? exp_pc + 6'd1 : exp_pc;
    sb.push_back(e);
    Write_IR = 1'b1; Write_PC = wpc; mem_rdata = rdata; mem_ack = (n == 1);
    @(posedge clk); #1;
    Write_IR = poke; Write_PC = poke;
    rc = 0; done = 1'b0;
    for (int j = 0; j < 40 && !done; j++) begin
      if (busy) begin
        rc++;
        tests_run++;
        if (mem_addr !== exp_pc || mem_req !== 1'b1 || ir_valid !== 1'b0 || flag !== 1'b0) begin
          tests_failed++;
          $display("FAIL req_phase: addr=%0d req=%b v=%b flag=%b, want addr=%0d req=1 v=0 flag=0",
                   mem_addr, mem_req, ir_valid, flag, exp_pc);
        end
      end
      mem_ack = (j + 1 == n);
      @(posedge clk); #1;
      if (ir_valid || fetch_err) done = 1'b1;
    end
    mem_ack = 1'b0; Write_IR = 1'b0; Write_PC = 1'b0;
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL fetch_bound: no completion within 40 cycles");
    end
    got = sb.pop_front();
    tests_run++;
    if (ir_valid !== got.valid || fetch_err !== got.err || IR !== got.ir ||
        Inst_addr !== got.pc || mem_addr !== got.pc || busy !== 1'b0 || mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_done: v=%b err=%b IR=%h pc=%0d addr=%0d busy=%b req=%b, want v=%b err=%b IR=%h pc=%0d busy=0 req=0",
               ir_valid, fetch_err, IR, Inst_addr, mem_addr, busy, mem_req,
               got.valid, got.err, got.ir, got.pc);
    end
    exp_pc = got.pc;
    exp_ir = got.ir;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Write_PC = 1'b0; Write_IR = 1'b0; NZCV = 4'b0100;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || Inst_addr !== 6'd0 || IR !== 32'h0 || ir_valid !== 1'b0 ||
        flag !== 1'b0 || busy !== 1'b0 || fetch_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: req=%b pc=%0d IR=%h v=%b flag=%b busy=%b err=%b, want all 0",
               mem_req, Inst_addr, IR, ir_valid, flag, busy, fetch_err);
    end
    Rst = 1'b0;
    exp_pc = 6'd0; exp_ir = 32'h0;
  endtask

  task automatic test_basic();
    int rc;
    NZCV = 4'b0000;
    run_fetch(1'b1, 32'hE081_0002, 1, 1'b0, rc);
    tests_run++;
    if (rc !== 1 || flag !== 1'b1 || Inst_addr !== 6'd1 || IR !== 32'hE081_0002) begin
      tests_failed++;
      $display("FAIL basic_fetch: req_cycles=%0d flag=%b pc=%0d IR=%h, want 1 1 1 e0810002",
               rc, flag, Inst_addr, IR);
    end
  endtask

  task automatic test_wait();
    int rc;
    run_fetch(1'b0, 32'h1A2B_3C4D, 5, 1'b0, rc);
    tests_run++;
    if (rc !== 5) begin
      tests_failed++;
      $display("FAIL wait_busy: busy_cycles=%0d, want 5", rc);
    end
  endtask

  task automatic test_cond();
    int rc;
    for (int c = 0; c < 16; c++) begin
      run_fetch(1'b0, {c[3:0], 28'h012_3456}, 1, 1'b0, rc);
      for (int f = 0; f < 16; f++) begin
        NZCV = f[3:0];
        #1;
        tests_run++;
        if (flag !== ref_cond(c[3:0], f[3:0])) begin
          tests_failed++;
          $display("FAIL cond: code=%h nzcv=%b flag=%b, want %b", c, f[3:0], flag,
                   ref_cond(c[3:0], f[3:0]));
        end
      end
    end
  endtask

  task automatic test_timeout();
    int rc;
    run_fetch(1'b1, 32'hDEAD_BEEF, 0, 1'b0, rc);
    tests_run++;
    if (rc !== TIMEOUT) begin
      tests_failed++;
      $display("FAIL timeout_len: req_cycles=%0d, want %0d", rc, TIMEOUT);
    end
    @(posedge clk); #1;
    tests_run++;
    if (fetch_err !== 1'b0 || busy !== 1'b0 || ir_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pulse: err=%b busy=%b v=%b, want 0 0 0", fetch_err, busy, ir_valid);
    end
    // Ack on the last allowed cycle completes; one cycle later is too late.
    run_fetch(1'b1, 32'hA000_0015, TIMEOUT, 1'b0, rc);
    tests_run++;
    if (rc !== TIMEOUT) begin
      tests_failed++;
      $display("FAIL ack_at_limit: req_cycles=%0d, want %0d", rc, TIMEOUT);
    end
    run_fetch(1'b1, 32'hB000_0016, TIMEOUT + 1, 1'b0, rc);
  endtask

  task automatic test_ignored();
    int rc;
    // Write_PC alone in HOLD must not move PC or start a fetch.
    run_fetch(1'b0, 32'hE000_0001, 1, 1'b0, rc);
    Write_PC = 1'b1;
    @(posedge clk); #1;
    Write_PC = 1'b0;
    tests_run++;
    if (Inst_addr !== exp_pc || busy !== 1'b0 || ir_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wpc_alone: pc=%0d busy=%b v=%b, want pc=%0d busy=0 v=1",
               Inst_addr, busy, ir_valid, exp_pc);
    end
    // Write_IR/Write_PC during REQ are not queued.
    run_fetch(1'b0, 32'hE000_0002, 4, 1'b1, rc);
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || Inst_addr !== exp_pc) begin
      tests_failed++;
      $display("FAIL no_queue: busy=%b pc=%0d, want busy=0 pc=%0d", busy, Inst_addr, exp_pc);
    end
  endtask

  task automatic test_wrap();
    int rc;
    for (int i = 0; i < 64 && exp_pc != 6'd63; i++)
      run_fetch(1'b1, 32'hE000_0000 | i, 1, 1'b0, rc);
    tests_run++;
    if (Inst_addr !== 6'd63) begin
      tests_failed++;
      $display("FAIL wrap_setup: pc=%0d, want 63", Inst_addr);
    end
    run_fetch(1'b1, 32'hE0FF_FFFF, 3, 1'b1, rc);
    tests_run++;
    if (Inst_addr !== 6'd0) begin
      tests_failed++;
      $display("FAIL pc_wrap: pc=%0d, want 0", Inst_addr);
    end
  endtask

  task automatic test_reset_mid_req();
    int rc;
    run_fetch(1'b1, 32'hE000_00AA, 1, 1'b0, rc);
    NZCV = 4'b0100;
    Write_IR = 1'b1;
    @(posedge clk); #1;
    Write_IR = 1'b0;
    @(posedge clk); #1;
    Rst = 1'b1;
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || Inst_addr !== 6'd0 || ir_valid !== 1'b0 || flag !== 1'b0 ||
        busy !== 1'b0 || IR !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_req: req=%b pc=%0d v=%b flag=%b busy=%b IR=%h, want all 0",
               mem_req, Inst_addr, ir_valid, flag, busy, IR);
    end
    @(negedge clk);
    Rst = 1'b0;
    exp_pc = 6'd0; exp_ir = 32'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_cond();
    test_timeout();
    test_ignored();
    test_wrap();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
